// File: rtl/int_divider.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring division, one quotient bit per clock.
// Divide-by-zero and signed overflow bypass the iteration and finish in a single cycle.
module int_divider #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIN  = 2'b10
    } state_t;

    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             op_rem_q, op_rem_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Operand decode for a new request
    logic            op_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] special_res;
    logic            accept;

    always_comb begin
        op_signed   = ~div_op[0];
        a_neg       = op_signed & dividend[XLEN-1];
        b_neg       = op_signed & divisor[XLEN-1];
        a_mag       = a_neg ? ((~dividend) + XLEN'(1)) : dividend;
        b_mag       = b_neg ? ((~divisor) + XLEN'(1)) : divisor;
        div_zero    = (divisor == '0);
        overflow    = op_signed && (dividend == INT_MIN) && (divisor == '1);
        // Zero divisor wins; otherwise this is overflow, where the quotient equals the dividend
        if (div_zero) begin
            special_res = div_op[1] ? dividend : '1;
        end else begin
            special_res = div_op[1] ? '0 : dividend;
        end
        accept      = start && !busy_q && (state_q != S_CALC);
    end

    // One restoring step: shift remainder left through the quotient MSB, subtract if it fits
    logic [XLEN:0]   rem_shift;
    logic [XLEN-1:0] rem_diff;
    logic            no_borrow;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] res_fin;

    always_comb begin
        rem_shift = {rem_q, quo_q[XLEN-1]};
        no_borrow = (rem_shift >= {1'b0, dvs_q});
        rem_diff  = XLEN'(rem_shift - {1'b0, dvs_q});
        rem_next  = no_borrow ? rem_diff : rem_shift[XLEN-1:0];
        quo_next  = {quo_q[XLEN-2:0], no_borrow};
        quo_fix   = neg_quo_q ? ((~quo_next) + XLEN'(1)) : quo_next;
        rem_fix   = neg_rem_q ? ((~rem_next) + XLEN'(1)) : rem_next;
        res_fin   = op_rem_q ? rem_fix : quo_fix;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            op_rem_q  <= 1'b0;
            res_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            op_rem_q  <= op_rem_d;
            res_q     <= res_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        op_rem_d  = op_rem_q;
        res_d     = res_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_CALC: begin
                busy_d = 1'b1;
                rem_d  = rem_next;
                quo_d  = quo_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    res_d   = res_fin;
                    cnt_d   = '0;
                end
            end
            S_IDLE, S_FIN: begin
                state_d = S_IDLE;
                if (accept) begin
                    op_rem_d = div_op[1];
                    cnt_d    = '0;
                    rem_d    = '0;
                    if (div_zero || overflow) begin
                        state_d   = S_FIN;
                        done_d    = 1'b1;
                        res_d     = special_res;
                        quo_d     = '0;
                        dvs_d     = '0;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                    end else begin
                        state_d   = S_CALC;
                        busy_d    = 1'b1;
                        quo_d     = a_mag;
                        dvs_d     = b_mag;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pipeline kill: drop everything except the last result
        if (flush) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = '0;
            dvs_d     = '0;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            op_rem_d  = 1'b0;
            res_d     = res_q;
            busy_d    = 1'b0;
            done_d    = 1'b0;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = res_q;

endmodule
